// File: rtl/axis_frame_sink.sv
// axis_frame_sink: reference sink and framing checker for the Axis stream bundle.
// It accepts a raster frame of Width x Height beats, checks sof/eol against that
// geometry, counts completed frames and raises sticky framing error flags.
// s_ready follows a fixed 16-cycle backpressure pattern and never looks at s_valid.
// Optional feature: define AXIS_FRAME_SINK_CHECKSUM_EN to add a 32-bit per-frame
// data checksum output.
module axis_frame_sink #(
    parameter int          DataWidth    = 8,
    parameter int          Width        = 8,
    parameter int          Height       = 8,
    parameter logic [15:0] ReadyPattern = 16'hFFFF,
    parameter int          CntWidth     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DataWidth-1:0] s_data,
    input  logic                 s_valid,
    input  logic                 s_sof,
    input  logic                 s_eol,
    output logic                 s_ready,
    input  logic                 enable,
    input  logic                 err_clr,
    output logic                 frame_done,
    output logic [CntWidth-1:0]  frame_count,
    output logic [3:0]           err_flags,
`ifdef AXIS_FRAME_SINK_CHECKSUM_EN
    output logic [31:0]          checksum,
`endif
    output logic                 in_frame
);

    localparam int ColW = (Width  > 1) ? $clog2(Width)  : 1;
    localparam int RowW = (Height > 1) ? $clog2(Height) : 1;
    localparam logic [ColW-1:0] LastCol = ColW'(Width - 1);
    localparam logic [RowW-1:0] LastRow = RowW'(Height - 1);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t          state;
    logic [3:0]      ptr;
    logic [ColW-1:0] col;
    logic [RowW-1:0] row;
    logic [ColW-1:0] col_eff;
    logic [RowW-1:0] row_eff;
    logic            beat;
    logic            restart;
    logic            take;
    logic            last_col;
    logic            line_end;
    logic            frame_end;
    logic [3:0]      new_err;

    // Beat decode: a sof beat (or any beat taken from IDLE) is processed as column 0 of row 0.
    always_comb begin
        beat       = s_valid & s_ready;
        restart    = s_sof | (state == IDLE);
        take       = beat & (s_sof | (state == FRAME));
        col_eff    = restart ? '0 : col;
        row_eff    = restart ? '0 : row;
        last_col   = (col_eff == LastCol);
        line_end   = s_eol | last_col;
        frame_end  = line_end & (row_eff == LastRow);
        new_err[0] = beat & ~s_sof & (state == IDLE);
        new_err[1] = beat &  s_sof & (state == FRAME);
        new_err[2] = take &  s_eol & ~last_col;
        new_err[3] = take & ~s_eol &  last_col;
    end

    // Backpressure generator: registered ready from the pattern, pointer frozen while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= 4'd0;
            s_ready <= 1'b0;
        end else if (enable) begin
            ptr     <= ptr + 4'd1;
            s_ready <= ReadyPattern[ptr];
        end else begin
            s_ready <= 1'b0;
        end
    end

    // Framing FSM with position counters, frame counter, done pulse and sticky errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_frame    <= 1'b0;
            col         <= '0;
            row         <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            err_flags   <= 4'd0;
        end else begin
            frame_done <= 1'b0;
            // A new error wins over a simultaneous clear.
            err_flags  <= (err_clr ? 4'd0 : err_flags) | new_err;
            if (take) begin
                if (frame_end) begin
                    state       <= IDLE;
                    in_frame    <= 1'b0;
                    col         <= '0;
                    row         <= '0;
                    frame_count <= frame_count + CntWidth'(1);
                    frame_done  <= 1'b1;
                end else begin
                    state    <= FRAME;
                    in_frame <= 1'b1;
                    if (line_end) begin
                        col <= '0;
                        row <= row_eff + RowW'(1);
                    end else begin
                        col <= col_eff + ColW'(1);
                    end
                end
            end
        end
    end

`ifdef AXIS_FRAME_SINK_CHECKSUM_EN
    logic [31:0] sum;
    logic [31:0] sum_next;

    // Running frame sum; a sof beat starts a fresh sum.
    always_comb begin
        sum_next = (s_sof ? 32'd0 : sum) + 32'(s_data);
    end

    // Accumulate on accepted beats and latch the final sum alongside frame_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum      <= 32'd0;
            checksum <= 32'd0;
        end else if (take) begin
            sum <= sum_next;
            if (frame_end) begin
                checksum <= sum_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_frame_sink.sv
// Directed testbench for axis_frame_sink: a 4x2 sink with full ready, a 4x2 sink
// with alternating ready, and a 1x1 sink for the degenerate geometry.
`timescale 1ns/1ps
module tb_axis_frame_sink;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_sof;
    logic       s_eol;
    logic       err_clr;

    logic        valid_a, enable_a, ready_a, done_a, inf_a;
    logic [15:0] cnt_a;
    logic [3:0]  err_a;
    logic        valid_b, enable_b, ready_b, done_b, inf_b;
    logic [15:0] cnt_b;
    logic [3:0]  err_b;
    logic        valid_c, enable_c, ready_c, done_c, inf_c;
    logic [15:0] cnt_c;
    logic [3:0]  err_c;
`ifdef AXIS_FRAME_SINK_CHECKSUM_EN
    logic [31:0] sum_a, sum_b, sum_c;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axis_frame_sink #(.DataWidth(8), .Width(4), .Height(2), .ReadyPattern(16'hFFFF), .CntWidth(16)) dut_a (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(valid_a), .s_sof(s_sof), .s_eol(s_eol),
        .s_ready(ready_a), .enable(enable_a), .err_clr(err_clr), .frame_done(done_a),
        .frame_count(cnt_a), .err_flags(err_a),
`ifdef AXIS_FRAME_SINK_CHECKSUM_EN
        .checksum(sum_a),
`endif
        .in_frame(inf_a));

    axis_frame_sink #(.DataWidth(8), .Width(4), .Height(2), .ReadyPattern(16'hAAAA), .CntWidth(16)) dut_b (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(valid_b), .s_sof(s_sof), .s_eol(s_eol),
        .s_ready(ready_b), .enable(enable_b), .err_clr(err_clr), .frame_done(done_b),
        .frame_count(cnt_b), .err_flags(err_b),
`ifdef AXIS_FRAME_SINK_CHECKSUM_EN
        .checksum(sum_b),
`endif
        .in_frame(inf_b));

    axis_frame_sink #(.DataWidth(8), .Width(1), .Height(1), .ReadyPattern(16'hFFFF), .CntWidth(16)) dut_c (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(valid_c), .s_sof(s_sof), .s_eol(s_eol),
        .s_ready(ready_c), .enable(enable_c), .err_clr(err_clr), .frame_done(done_c),
        .frame_count(cnt_c), .err_flags(err_c),
`ifdef AXIS_FRAME_SINK_CHECKSUM_EN
        .checksum(sum_c),
`endif
        .in_frame(inf_c));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One beat on the selected sink (0=a, 2=c); returns 1 ns after the accepting edge.
    task automatic send(input int which, input logic [7:0] d, input logic sof, input logic eol);
        s_data = d;
        s_sof  = sof;
        s_eol  = eol;
        valid_a = (which == 0);
        valid_c = (which == 2);
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_c = 1'b0;
    endtask

    // Full well-formed 4x2 frame on sink a with data base+1 .. base+8.
    task automatic good_frame(input logic [7:0] base);
        for (int i = 0; i < 8; i++) send(0, base + 8'(i + 1), (i == 0), (i == 3 || i == 7));
    endtask

    initial begin
        logic r;
        int   k;
        int   cyc;
        rst = 1'b1;
        s_data = 8'd0; s_sof = 1'b0; s_eol = 1'b0; err_clr = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        enable_a = 1'b0; enable_b = 1'b0; enable_c = 1'b0;
        #3;
        check_val("reset_ready",  ready_a, 0);
        check_val("reset_done",   done_a, 0);
        check_val("reset_count",  cnt_a, 0);
        check_val("reset_err",    err_a, 0);
        check_val("reset_inframe", inf_a, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        enable_a = 1'b1; enable_b = 1'b1; enable_c = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check_val("ready_on", ready_a, 1);

        // Well-formed frame, data 1..8
        for (int i = 0; i < 8; i++) begin
            send(0, 8'(i + 1), (i == 0), (i == 3 || i == 7));
            if (i == 0) check_val("t1_inframe", inf_a, 1);
            if (i == 6) check_val("t1_done_early", done_a, 0);
        end
        check_val("t1_done", done_a, 1);
        check_val("t1_count", cnt_a, 1);
        check_val("t1_err", err_a, 0);
        check_val("t1_inframe_end", inf_a, 0);
`ifdef AXIS_FRAME_SINK_CHECKSUM_EN
        check_val("t1_checksum", sum_a, 36);
`endif
        @(posedge clk); #1;
        check_val("t1_done_pulse", done_a, 0);

        // Missing sof: beat discarded, then a good frame completes
        send(0, 8'd5, 1'b0, 1'b0);
        check_val("t3_err0", err_a, 4'b0001);
        check_val("t3_inframe", inf_a, 0);
        good_frame(8'd0);
        check_val("t3_count", cnt_a, 2);
        check_val("t3_done", done_a, 1);
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
        check_val("clr_err", err_a, 0);

        // Early eol on 2nd beat of line 0: frame ends after 2+4 beats
        for (int i = 0; i < 6; i++) begin
            send(0, 8'(i + 1), (i == 0), (i == 1 || i == 5));
            if (i == 4) check_val("t4_not_done", done_a, 0);
        end
        check_val("t4_done", done_a, 1);
        check_val("t4_err", err_a, 4'b0100);
        check_val("t4_count", cnt_a, 3);
`ifdef AXIS_FRAME_SINK_CHECKSUM_EN
        check_val("t4_checksum", sum_a, 21);
`endif
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;

        // Unexpected sof on 3rd beat restarts the frame
        send(0, 8'd100, 1'b1, 1'b0);
        send(0, 8'd100, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send(0, 8'(i + 1), (i == 0), (i == 3 || i == 7));
            if (i == 6) check_val("t5_not_done", done_a, 0);
        end
        check_val("t5_done", done_a, 1);
        check_val("t5_err", err_a, 4'b0010);
        check_val("t5_count", cnt_a, 4);
`ifdef AXIS_FRAME_SINK_CHECKSUM_EN
        check_val("t5_checksum", sum_a, 36);
`endif

        // Clear together with a new error: old flag clears, new one stays
        err_clr = 1'b1;
        send(0, 8'd55, 1'b0, 1'b0);
        err_clr = 1'b0;
        check_val("clr_prio", err_a, 4'b0001);
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;

        // Missing eol at last column, then a back-to-back good frame
        for (int i = 0; i < 8; i++) send(0, 8'(i + 1), (i == 0), (i == 7));
        check_val("t6_err3", err_a, 4'b1000);
        check_val("t6_count", cnt_a, 5);
        good_frame(8'd10);
        check_val("b2b_err", err_a, 4'b1000);
        check_val("b2b_count", cnt_a, 6);
`ifdef AXIS_FRAME_SINK_CHECKSUM_EN
        check_val("b2b_checksum", sum_a, 116);
`endif

        // Alternating ready on sink b, valid held high
        k = 0;
        cyc = 0;
        while (k < 8 && cyc < 64) begin
            s_data = 8'(k + 1);
            s_sof  = (k == 0);
            s_eol  = (k == 3 || k == 7);
            valid_b = 1'b1;
            r = ready_b;
            @(posedge clk); #1;
            check_val("b_toggle", ready_b, {31'd0, ~r});
            if (r) k++;
            cyc++;
        end
        valid_b = 1'b0;
        check_val("b_beats", k, 8);
        check_val("b_done", done_b, 1);
        check_val("b_count", cnt_b, 1);
        check_val("b_err", err_b, 0);
`ifdef AXIS_FRAME_SINK_CHECKSUM_EN
        check_val("b_checksum", sum_b, 36);
`endif

        // Width=1, Height=1: every sof beat is a whole frame
        for (int i = 0; i < 3; i++) begin
            send(2, 8'(i), 1'b1, 1'b1);
            check_val("c_done", done_c, 1);
        end
        check_val("c_count", cnt_c, 3);
        check_val("c_err", err_c, 0);
        check_val("c_inframe", inf_c, 0);
        send(2, 8'd9, 1'b1, 1'b0);
        check_val("c_err3", err_c, 4'b1000);
        check_val("c_count4", cnt_c, 4);

        // Reset in the middle of a frame, checked before the next clock edge
        send(0, 8'd1, 1'b1, 1'b0);
        send(0, 8'd2, 1'b0, 1'b0);
        check_val("rst_pre_inframe", inf_a, 1);
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_count", cnt_a, 0);
        check_val("rst_err", err_a, 0);
        check_val("rst_inframe", inf_a, 0);
        check_val("rst_ready", ready_a, 0);
        check_val("rst_done", done_a, 0);
        check_val("rst_count_c", cnt_c, 0);
`ifdef AXIS_FRAME_SINK_CHECKSUM_EN
        check_val("rst_checksum", sum_a, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
